// File: rtl/traffic_pkg.sv
// Shared intersection constants: segment codes, 50 MHz timings, crossing FSM states.
// Used by crossing_scheduler, button_conditioner and traffic_light_controller.
package traffic_pkg;

  localparam logic [7:0] GREEN_SEG   = 8'b1000_0010;
  localparam logic [7:0] YELLOW_SEG  = 8'b1001_1001;
  localparam logic [7:0] RED_SEG     = 8'b1000_1000;
  localparam logic [7:0] RED_ALT_SEG = 8'b1000_0000;
  localparam logic [7:0] ERROR_SEG   = 8'b1000_0110;
  localparam logic [7:0] OFF_SEG     = 8'b1111_1111;

  localparam int unsigned DEBOUNCE_50M = 1_000_000;
  localparam int unsigned REQ_PULSE_50M = 4;
  localparam int unsigned SERVE_TO_50M = 1_000_000_000;
  localparam int unsigned WALK_50M = 350_000_000;
  localparam int unsigned FLASH_50M = 150_000_000;
  localparam int unsigned BLINK_50M = 25_000_000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WALK,
    FLASH
  } cross_state_e;

  function automatic logic seg_normal(logic [7:0] s);
    return (s == GREEN_SEG) || (s == YELLOW_SEG) ||
           (s == RED_SEG) || (s == RED_ALT_SEG);
  endfunction

endpackage

// File: rtl/crossing_scheduler_if.sv
// Link between crossing_scheduler and the light controller.
// Lights flow controller->scheduler; pedestrian requests flow back.
interface crossing_scheduler_if;

  logic [7:0] ns_light;
  logic [7:0] ew_light;
  logic       ns_pedestrian;
  logic       ew_pedestrian;

  modport master (
    output ns_light,
    output ew_light,
    input  ns_pedestrian,
    input  ew_pedestrian
  );

  modport slave (
    input  ns_light,
    input  ew_light,
    output ns_pedestrian,
    output ew_pedestrian
  );

endinterface

// File: rtl/button_conditioner.sv
// 2-FF synchroniser + debounce; one-cycle press pulse per stable press.
// Ports: clk, reset (async high), button (raw), press (pulse).
module button_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50M
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam logic [31:0] FULL = 32'(DEBOUNCE_CYCLES);
  localparam logic [31:0] LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic [31:0] cnt;

  // Counter saturates at FULL so the pulse cannot re-fire until release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      press <= 1'b0;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != FULL) begin
        cnt   <= cnt + 32'd1;
        press <= (cnt == LAST);
      end
    end
  end

endmodule

// File: rtl/crossing_scheduler.sv
// Pedestrian front end: debounce, pending latch, round-robin request, WALK/FLASH.
// Ports: clk, reset, ns/ew_button, ctl (lights in, requests out), walk/dont_walk/pending lamps.
module crossing_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50M,
  parameter int unsigned REQ_PULSE = REQ_PULSE_50M,
  parameter int unsigned SERVE_TIMEOUT = SERVE_TO_50M,
  parameter int unsigned WALK_TIME = WALK_50M,
  parameter int unsigned FLASH_TIME = FLASH_50M,
  parameter int unsigned BLINK_HALF = BLINK_50M
) (
  input  logic clk,
  input  logic reset,
  input  logic ns_button,
  input  logic ew_button,
  crossing_scheduler_if.slave ctl,
  output logic ns_walk,
  output logic ew_walk,
  output logic ns_dont_walk,
  output logic ew_dont_walk,
  output logic ns_pending,
  output logic ew_pending
);

  localparam logic [31:0] REQ_LAST = 32'(REQ_PULSE - 1);
  localparam logic [31:0] TO_LAST = 32'(SERVE_TIMEOUT - 1);
  localparam logic [31:0] WALK_LAST = 32'(WALK_TIME - 1);
  localparam logic [31:0] FLASH_LAST = 32'(FLASH_TIME - 1);
  localparam logic [31:0] BLINK_W = 32'(BLINK_HALF);

  logic ns_press;
  logic ew_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ns_btn (
    .clk(clk),
    .reset(reset),
    .button(ns_button),
    .press(ns_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ew_btn (
    .clk(clk),
    .reset(reset),
    .button(ew_button),
    .press(ew_press)
  );

  cross_state_e state;
  logic [31:0]  cnt;
  logic         sel_ew;
  logic         gnt_ew;
  logic         ns_req;
  logic         ew_req;

  logic        normal;
  logic        ns_green;
  logic        ew_green;
  logic        pick_ew;
  logic        pick_green;
  logic        sel_green;
  logic        idle_go;
  logic        abort;
  logic        enter_walk;
  logic        walk_ew;
  logic [31:0] cnt_nx;
  logic        blink_edge;

  assign ctl.ns_pedestrian = ns_req;
  assign ctl.ew_pedestrian = ew_req;

  assign normal = seg_normal(ctl.ns_light) && seg_normal(ctl.ew_light);
  assign ns_green = (ctl.ns_light == GREEN_SEG);
  assign ew_green = (ctl.ew_light == GREEN_SEG);

  // Both pending: grant pointer decides; otherwise whoever is pending.
  assign pick_ew = (ns_pending && ew_pending) ? gnt_ew : ew_pending;
  assign pick_green = pick_ew ? ew_green : ns_green;
  assign sel_green = sel_ew ? ew_green : ns_green;

  assign idle_go = (state == IDLE) && normal && (ns_pending || ew_pending);

  assign abort = (state != IDLE) &&
                 (!normal ||
                  (((state == WALK) || (state == FLASH)) && !sel_green));

  assign enter_walk = !abort &&
                      ((idle_go && pick_green) ||
                       ((state == WAIT) && sel_green));
  assign walk_ew = (state == IDLE) ? pick_ew : sel_ew;

  assign cnt_nx = cnt + 32'd1;
  assign blink_edge = ((cnt_nx % BLINK_W) == 32'd0);

  // A fresh press wins over the clear so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ns_pending <= 1'b0;
      ew_pending <= 1'b0;
    end else begin
      ns_pending <= ns_press | (ns_pending & ~(enter_walk & ~walk_ew));
      ew_pending <= ew_press | (ew_pending & ~(enter_walk & walk_ew));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sel_ew       <= 1'b0;
      gnt_ew       <= 1'b0;
      ns_req       <= 1'b0;
      ew_req       <= 1'b0;
      ns_walk      <= 1'b0;
      ew_walk      <= 1'b0;
      ns_dont_walk <= 1'b1;
      ew_dont_walk <= 1'b1;
    end else if (abort) begin
      state        <= IDLE;
      cnt          <= '0;
      ns_req       <= 1'b0;
      ew_req       <= 1'b0;
      ns_walk      <= 1'b0;
      ew_walk      <= 1'b0;
      ns_dont_walk <= 1'b1;
      ew_dont_walk <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (idle_go) begin
            sel_ew <= pick_ew;
            cnt    <= '0;
            if (pick_green) begin
              state        <= WALK;
              ns_walk      <= ~pick_ew;
              ew_walk      <= pick_ew;
              ns_dont_walk <= pick_ew;
              ew_dont_walk <= ~pick_ew;
            end else begin
              state  <= REQ;
              ns_req <= ~pick_ew;
              ew_req <= pick_ew;
            end
          end
        end
        REQ: begin
          if (cnt == REQ_LAST) begin
            state  <= WAIT;
            cnt    <= '0;
            ns_req <= 1'b0;
            ew_req <= 1'b0;
          end else begin
            cnt <= cnt_nx;
          end
        end
        WAIT: begin
          if (sel_green) begin
            state        <= WALK;
            cnt          <= '0;
            ns_walk      <= ~sel_ew;
            ew_walk      <= sel_ew;
            ns_dont_walk <= sel_ew;
            ew_dont_walk <= ~sel_ew;
          end else if (cnt == TO_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nx;
          end
        end
        WALK: begin
          if (cnt == WALK_LAST) begin
            state        <= FLASH;
            cnt          <= '0;
            ns_walk      <= 1'b0;
            ew_walk      <= 1'b0;
            ns_dont_walk <= 1'b1;
            ew_dont_walk <= 1'b1;
          end else begin
            cnt <= cnt_nx;
          end
        end
        FLASH: begin
          if (cnt == FLASH_LAST) begin
            state        <= IDLE;
            cnt          <= '0;
            ns_dont_walk <= 1'b1;
            ew_dont_walk <= 1'b1;
            gnt_ew       <= ~sel_ew;
          end else begin
            cnt <= cnt_nx;
            if (blink_edge) begin
              if (sel_ew) ew_dont_walk <= ~ew_dont_walk;
              else ns_dont_walk <= ~ns_dont_walk;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossing_scheduler.sv
// Self-checking bench for crossing_scheduler with short timing overrides.
// Table-driven NS service plus hand sequences for arbitration, timeout, abort, reset.
module tb_crossing_scheduler;
  import traffic_pkg::*;

  typedef struct {
    logic       nsb;
    logic       ewb;
    logic [7:0] nsl;
    logic [7:0] ewl;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ns_button;
  logic ew_button;
  logic ns_walk;
  logic ew_walk;
  logic ns_dont_walk;
  logic ew_dont_walk;
  logic ns_pending;
  logic ew_pending;

  crossing_scheduler_if bus ();

  crossing_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .REQ_PULSE(2),
    .SERVE_TIMEOUT(50),
    .WALK_TIME(10),
    .FLASH_TIME(8),
    .BLINK_HALF(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ns_button(ns_button),
    .ew_button(ew_button),
    .ctl(bus),
    .ns_walk(ns_walk),
    .ew_walk(ew_walk),
    .ns_dont_walk(ns_dont_walk),
    .ew_dont_walk(ew_dont_walk),
    .ns_pending(ns_pending),
    .ew_pending(ew_pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  localparam logic [7:0] IDLE_V = 8'b0001_0100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ns_button = 1'b0;
    ew_button = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic add(input logic nsb, input logic ewb,
                     input logic [7:0] nsl, input logic [7:0] ewl,
                     input logic [7:0] exp);
    vec_t v;
    v.nsb = nsb;
    v.ewb = ewb;
    v.nsl = nsl;
    v.ewl = ewl;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  // {ns_ped, ew_ped, ns_walk, ns_dw, ew_walk, ew_dw, ns_pend, ew_pend}
  function automatic logic [7:0] obs();
    return {bus.ns_pedestrian, bus.ew_pedestrian, ns_walk, ns_dont_walk,
            ew_walk, ew_dont_walk, ns_pending, ew_pending};
  endfunction

  initial begin
    int rises;
    int rise_at;
    logic prev;

    reset = 1'b1;
    ns_button = 1'b0;
    ew_button = 1'b0;
    bus.ns_light = RED_SEG;
    bus.ew_light = GREEN_SEG;
    #2;
    chk("reset_outputs", 32'(obs()), 32'(IDLE_V));
    chk("reset_state", 32'(dut.state), 32'(IDLE));

    // Bounce with lights in override so the FSM stays idle.
    do_reset();
    bus.ns_light = OFF_SEG;
    bus.ew_light = OFF_SEG;
    rises = 0;
    rise_at = 0;
    prev = ns_pending;
    for (int i = 0; i < 4; i++) begin
      ns_button = (i % 2 == 0);
      step();
      if (ns_pending && !prev) rises++;
      prev = ns_pending;
    end
    ns_button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (ns_pending && !prev) begin
        rises++;
        rise_at = i;
      end
      prev = ns_pending;
    end
    ns_button = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ns_pending && !prev) rises++;
      prev = ns_pending;
    end
    chk("bounce_rises", 32'(rises), 32'd1);
    chk("bounce_latency", 32'(rise_at), 32'd7);
    chk("override_no_req", 32'(bus.ns_pedestrian), 32'd0);
    chk("override_idle", 32'(dut.state), 32'(IDLE));

    // Table: NS request, NS green arrives, walk and flash.
    for (int i = 1; i <= 6; i++) add(1, 0, RED_SEG, GREEN_SEG, IDLE_V);
    add(0, 0, RED_SEG, GREEN_SEG, 8'b0001_0110);
    for (int i = 0; i < 2; i++) add(0, 0, RED_SEG, GREEN_SEG, 8'b1001_0110);
    for (int i = 0; i < 4; i++) add(0, 0, RED_SEG, GREEN_SEG, 8'b0001_0110);
    for (int i = 0; i < 10; i++) add(0, 0, GREEN_SEG, RED_SEG, 8'b0010_0100);
    for (int k = 0; k < 8; k++)
      add(0, 0, GREEN_SEG, RED_SEG,
          ((k % 4) < 2) ? 8'b0001_0100 : 8'b0000_0100);
    add(0, 0, GREEN_SEG, RED_SEG, IDLE_V);

    bus.ns_light = RED_SEG;
    bus.ew_light = GREEN_SEG;
    do_reset();
    foreach (tbl[i]) begin
      ns_button = tbl[i].nsb;
      ew_button = tbl[i].ewb;
      bus.ns_light = tbl[i].nsl;
      bus.ew_light = tbl[i].ewl;
      step();
      chk($sformatf("vec%0d", i + 1), 32'(obs()), 32'(tbl[i].exp));
    end
    chk("table_end_idle", 32'(dut.state), 32'(IDLE));

    // Simultaneous presses, then EW timeout, then reset in WAIT.
    bus.ns_light = RED_SEG;
    bus.ew_light = GREEN_SEG;
    do_reset();
    for (int e = 1; e <= 85; e++) begin
      ns_button = (e <= 6) || (e >= 40 && e <= 45);
      ew_button = (e <= 6);
      if (e >= 11) begin
        bus.ns_light = GREEN_SEG;
        bus.ew_light = RED_SEG;
      end
      step();
      case (e)
        8: begin
          chk("both_ns_first", 32'(bus.ns_pedestrian), 32'd1);
          chk("both_ew_held", 32'(bus.ew_pedestrian), 32'd0);
          chk("both_pending", 32'({ns_pending, ew_pending}), 32'd3);
        end
        11: chk("ns_walk_ew_pend", 32'({ns_walk, ns_pending, ew_pending}),
                32'b101);
        28: chk("ns_flash_last", 32'(dut.state), 32'(FLASH));
        29: chk("after_flash", 32'({dut.state, bus.ew_pedestrian}),
                32'({IDLE, 1'b0}));
        30: chk("ew_req_1", 32'(bus.ew_pedestrian), 32'd1);
        31: chk("ew_req_2", 32'(bus.ew_pedestrian), 32'd1);
        32: chk("ew_wait", 32'({dut.state, bus.ew_pedestrian}),
                32'({WAIT, 1'b0}));
        81: chk("wait_50", 32'(dut.state), 32'(WAIT));
        82: chk("timeout_idle", 32'({dut.state, ew_pending, bus.ew_pedestrian}),
                32'({IDLE, 2'b10}));
        83: chk("rereq_ew", 32'({bus.ns_pedestrian, bus.ew_pedestrian,
                                 ns_pending}), 32'b011);
        85: chk("wait_both_pend", 32'({dut.state, ns_pending, ew_pending}),
                32'({WAIT, 2'b11}));
        default: ;
      endcase
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 32'(obs()), 32'(IDLE_V));
    chk("async_reset_state", 32'(dut.state), 32'(IDLE));

    // Direct walk (already green), then error pattern aborts it.
    bus.ns_light = GREEN_SEG;
    bus.ew_light = RED_SEG;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      ns_button = (e <= 6);
      if (e == 11) bus.ns_light = ERROR_SEG;
      step();
      case (e)
        8: chk("direct_walk", 32'(obs()), 32'b0010_0100);
        10: chk("walk_hold", 32'(ns_walk), 32'd1);
        11: chk("abort", 32'({dut.state, ns_walk, ns_dont_walk}),
                32'({IDLE, 2'b01}));
        12: chk("abort_stay", 32'(obs()), 32'(IDLE_V));
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
